// File: rtl/prbs7_checker_pkg.sv
// rtl/prbs7_checker_pkg.sv - shared PRBS-7 polynomial definition and checker state type
//
// One polynomial definition for the PRBS-7 generator and checker:
//   s[n] = s[n-1] XOR s[n-7]
// History is held as h[7:1]. h[1] is the newest bit and h[7] is the oldest.
// No ports (package).

package prbs7_checker_pkg;

  // Checker state type.
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  // Sequence length. The taps are given as positions in h[7:1].
  localparam int PRBS_LEN     = 7;
  localparam int PRBS_TAP_NEW = 1;
  localparam int PRBS_TAP_OLD = 7;

  // Next sequence bit predicted from the history register.
  function automatic logic prbs7_predict(input logic [PRBS_LEN:1] hist);
    return hist[PRBS_TAP_NEW] ^ hist[PRBS_TAP_OLD];
  endfunction

endpackage

// File: rtl/prbs7_step.sv
// rtl/prbs7_step.sv - combinational PRBS-7 next-bit function
//
// Takes the history register h[7:1] and returns the next sequence bit.
// Ports:
//   hist_i  in  7  history, hist_i[1] newest
//   pred_o  out 1  predicted next bit

module prbs7_step
  import prbs7_checker_pkg::*;
(
  input  logic [PRBS_LEN:1] hist_i,
  output logic              pred_o
);

  assign pred_o = prbs7_predict(hist_i);

endmodule

// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - self-synchronising serial PRBS-7 checker
//
// Receives one bit on each cycle where bit_valid is high. The checker first
// fills its history register. It then searches for LOCK_COUNT consecutive
// correct predictions. After that it locks and compares each received bit
// against a free-running local copy of the sequence.
// Ports:
//   clk          in  1     clock, rising edge
//   reset        in  1     synchronous active-high reset
//   bit_valid    in  1     qualifies bit_in
//   bit_in       in  1     received serial bit
//   clear_count  in  1     synchronous clear of err_count
//   locked       out 1     high while locked
//   err_pulse    out 1     one-cycle pulse per bit error while locked
//   err_count    out ERRW  saturating error count (locked errors only)
//   lock_lost    out 1     sticky; set on every loss of lock

module prbs7_checker
  import prbs7_checker_pkg::*;
#(
  parameter int LOCK_COUNT  = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERRW        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bit_valid,
  input  logic            bit_in,
  input  logic            clear_count,
  output logic            locked,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_count,
  output logic            lock_lost
);

  localparam int MW = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT + 1)  : 1;
  localparam int WW = $clog2(WINDOW);
  localparam int EW = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;

  localparam logic [2:0]    FILL_LAST = 3'(PRBS_LEN - 1);
  localparam logic [MW-1:0] LOCK_TGT  = MW'(LOCK_COUNT);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
  localparam logic [EW-1:0] LOSS_TGT  = EW'(LOSS_THRESH);

  prbs_state_e       state_q,     state_d;
  logic [PRBS_LEN:1] hist_q,      hist_d;
  logic [2:0]        fill_q,      fill_d;
  logic [MW-1:0]     match_q,     match_d;
  logic [WW-1:0]     win_bit_q,   win_bit_d;
  logic [EW-1:0]     win_err_q,   win_err_d;
  logic              locked_q,    locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERRW-1:0]   err_count_q, err_count_d;
  logic              lock_lost_q, lock_lost_d;

  logic pred;
  logic err_hit;

  prbs7_step u_step (
    .hist_i (hist_q),
    .pred_o (pred)
  );

  // Next-state logic. Nothing advances unless a bit is accepted. The only
  // exceptions are err_pulse, which always returns to 0, and clear_count.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_bit_d   = win_bit_q;
    win_err_d   = win_err_q;
    locked_d    = locked_q;
    lock_lost_d = lock_lost_q;
    err_pulse_d = 1'b0;
    err_hit     = 1'b0;

    if (bit_valid) begin
      case (state_q)
        ST_FILL: begin
          hist_d = {hist_q[PRBS_LEN-1:1], bit_in};
          fill_d = fill_q + 3'd1;
          if (fill_q == FILL_LAST) begin
            state_d = ST_SEARCH;
            fill_d  = '0;
            match_d = '0;
          end
        end

        ST_SEARCH: begin
          hist_d = {hist_q[PRBS_LEN-1:1], bit_in};
          if (bit_in == pred) begin
            match_d = match_q + MW'(1);
          end else begin
            match_d = '0;
          end
          // An all-zero history predicts zero forever. A dead link must
          // never look like a lock, so the match run restarts here.
          if (hist_d == '0) begin
            match_d = '0;
          end
          if (match_d == LOCK_TGT) begin
            state_d   = ST_LOCKED;
            locked_d  = 1'b1;
            match_d   = '0;
            win_bit_d = '0;
            win_err_d = '0;
          end
        end

        ST_LOCKED: begin
          // The reference advances on its own prediction. Received errors
          // therefore never corrupt the local copy of the sequence.
          hist_d = {hist_q[PRBS_LEN-1:1], pred};
          if (bit_in != pred) begin
            err_hit     = 1'b1;
            err_pulse_d = 1'b1;
            win_err_d   = win_err_q + EW'(1);
          end
          // Loss is tested before the window wrap. An error on the last bit
          // of a window therefore still counts toward that window.
          if (err_hit && (win_err_d == LOSS_TGT)) begin
            state_d     = ST_FILL;
            fill_d      = '0;
            locked_d    = 1'b0;
            lock_lost_d = 1'b1;
          end else if (win_bit_q == WIN_LAST) begin
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            win_bit_d = win_bit_q + WW'(1);
          end
        end

        default: begin
          state_d  = ST_FILL;
          fill_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end

    // When a clear and an error land in the same cycle, the error survives
    // the clear.
    if (clear_count) begin
      err_count_d = err_hit ? ERRW'(1) : '0;
    end else if (err_hit && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERRW'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_bit_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_bit_q   <= win_bit_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - directed self-checking bench for prbs7_checker

module tb_prbs7_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset       = 1'b1;
  logic        bit_valid   = 1'b0;
  logic        bit_in      = 1'b0;
  logic        clear_count = 1'b0;

  logic        locked,  err_pulse,  lock_lost;
  logic [15:0] err_count;
  logic        locked4, err_pulse4, lock_lost4;
  logic [3:0]  err_count4;

  prbs7_checker dut (
    .clk         (clk),
    .reset       (reset),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .clear_count (clear_count),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .lock_lost   (lock_lost)
  );

  prbs7_checker #(.ERRW(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .clear_count (clear_count),
    .locked      (locked4),
    .err_pulse   (err_pulse4),
    .err_count   (err_count4),
    .lock_lost   (lock_lost4)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Expected outputs after the next clock edge.
  bit e_locked, e_pulse, e_lost;
  int e_cnt, e_cnt4;

  // Reference model. Received-sequence memory is kept as a queue, newest bit first.
  string m_state;
  bit    hq[$];
  int    m_fill, m_match, m_winpos, m_winerr;

  // Stimulus generator memory, newest bit first.
  bit    gq[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void gen_seed();
    gq = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic bit gen_bit();
    bit nb;
    nb = gq[0] ^ gq[6];
    gq.push_front(nb);
    void'(gq.pop_back());
    return nb;
  endfunction

  function automatic void model_step(bit rst, bit v, bit b, bit clr);
    bit p;
    bit any_one;
    if (rst) begin
      m_state  = "FILL";
      hq       = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      m_fill   = 0;
      m_match  = 0;
      m_winpos = 0;
      m_winerr = 0;
      e_locked = 0;
      e_pulse  = 0;
      e_lost   = 0;
      e_cnt    = 0;
      e_cnt4   = 0;
      return;
    end
    e_pulse = 0;
    if (clr) begin
      e_cnt  = 0;
      e_cnt4 = 0;
    end
    if (!v) return;
    p = hq[0] ^ hq[6];
    if (m_state == "FILL") begin
      hq.push_front(b);
      void'(hq.pop_back());
      m_fill++;
      if (m_fill == 7) begin
        m_state = "SEARCH";
        m_match = 0;
      end
    end else if (m_state == "SEARCH") begin
      m_match = (b == p) ? m_match + 1 : 0;
      hq.push_front(b);
      void'(hq.pop_back());
      any_one = 0;
      foreach (hq[i]) any_one |= hq[i];
      if (!any_one) m_match = 0;
      if (m_match == 16) begin
        m_state  = "LOCKED";
        e_locked = 1;
        m_winpos = 0;
        m_winerr = 0;
      end
    end else begin
      if (b != p) begin
        e_pulse = 1;
        if (e_cnt  < 65535) e_cnt++;
        if (e_cnt4 < 15)    e_cnt4++;
        m_winerr++;
      end
      hq.push_front(p);
      void'(hq.pop_back());
      m_winpos++;
      if (m_winerr == 8) begin
        m_state  = "FILL";
        m_fill   = 0;
        e_locked = 0;
        e_lost   = 1;
      end else if (m_winpos == 64) begin
        m_winpos = 0;
        m_winerr = 0;
      end
    end
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("locked",     locked,     e_locked);
      chk("err_pulse",  err_pulse,  e_pulse);
      chk("err_count",  err_count,  e_cnt);
      chk("lock_lost",  lock_lost,  e_lost);
      chk("locked4",    locked4,    e_locked);
      chk("err_pulse4", err_pulse4, e_pulse);
      chk("err_count4", err_count4, e_cnt4);
      chk("lock_lost4", lock_lost4, e_lost);
    end
  end

  // Applies one cycle of inputs. It returns after the edge has settled.
  task automatic send(bit rst, bit v, bit b, bit clr);
    @(negedge clk);
    reset       = rst;
    bit_valid   = v;
    bit_in      = b;
    clear_count = clr;
    model_step(rst, v, b, clr);
    chk_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic clean(int n);
    repeat (n) send(1'b0, 1'b1, gen_bit(), 1'b0);
  endtask

  task automatic send_err();
    send(1'b0, 1'b1, ~gen_bit(), 1'b0);
  endtask

  initial begin
    logic [7:0] first8;
    logic [6:0] st;
    int n;
    int guard;

    // Pin the stimulus generator: known opening bits and a period of 127.
    gen_seed();
    first8 = '0;
    for (int i = 0; i < 8; i++) first8 = {first8[6:0], gen_bit()};
    chk("gen_first8", first8, 8'hFD);
    for (int i = 8; i < 127; i++) void'(gen_bit());
    st = '0;
    for (int i = 0; i < 7; i++) st[i] = gq[i];
    chk("gen_period", st, 7'd1);
    gen_seed();

    // Reset with bit_valid high; reset must win.
    repeat (3) send(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_locked", locked, 0);
    chk("rst_count", err_count, 0);
    chk("rst_lost", lock_lost, 0);

    // Clean stream: lock after exactly 23 bits, no errors over 1000 bits.
    for (int i = 1; i <= 1000; i++) begin
      clean(1);
      if (i == 22) chk("lock_at_22", locked, 0);
      if (i == 23) chk("lock_at_23", locked, 1);
    end
    chk("clean_count", err_count, 0);

    // Single flipped bit.
    send_err();
    chk("single_pulse", err_pulse, 1);
    chk("single_count", err_count, 1);
    chk("single_locked", locked, 1);
    clean(1);
    chk("single_pulse_end", err_pulse, 0);
    clean(200);
    chk("single_no_more", err_count, 1);

    // Seven errors at window bits 57..63, then seven more in the next window.
    guard = 0;
    while (m_winpos != 56 && guard < 200) begin clean(1); guard++; end
    repeat (7) send_err();
    clean(1);
    repeat (7) send_err();
    chk("wrap_locked", locked, 1);
    chk("wrap_lost", lock_lost, 0);
    chk("wrap_count", err_count, 15);
    clean(100);

    // Eight errors in one window: lock drops on the eighth.
    guard = 0;
    while (m_winpos != 0 && guard < 200) begin clean(1); guard++; end
    for (int k = 1; k <= 8; k++) begin
      send_err();
      if (k == 7) chk("loss_7_locked", locked, 1);
      if (k < 8) clean(1);
    end
    chk("loss_locked", locked, 0);
    chk("loss_sticky", lock_lost, 1);
    n = 0;
    while (!locked && n < 100) begin clean(1); n++; end
    chk("relock_bits", n, 23);

    // Clear coincident with an error.
    send(1'b0, 1'b1, ~gen_bit(), 1'b1);
    chk("clr_err_count", err_count, 1);
    chk("clr_err_count4", err_count4, 1);
    clean(5);

    // Twenty spaced errors: ERRW=4 saturates at 15.
    send(1'b0, 1'b1, gen_bit(), 1'b1);
    for (int k = 0; k < 20; k++) begin
      send_err();
      clean(9);
    end
    chk("sat_count16", err_count, 20);
    chk("sat_count4", err_count4, 15);
    chk("sat_locked", locked, 1);

    // Mid-run reset, then a clean stream accepted one cycle in three.
    repeat (2) send(1'b1, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!locked && n < 300) begin
      send(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      send(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      send(1'b0, 1'b1, gen_bit(), 1'b0);
      n++;
    end
    chk("sparse_lock_bits", n, 23);
    chk("sparse_lost", lock_lost, 0);

    // An all-zero stream never locks.
    repeat (2) send(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (100) send(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero_locked", locked, 0);
    chk("zero_count", err_count, 0);

    chk_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
